frame_payload_extractor: RTL
============================

Name: frame_payload_extractor

Overview:
- Sits directly downstream of the frame aligner. Consumes the aligned byte stream (rx_data, fr_byte_position, frame_detect) and extracts the 10 payload bytes of every legal frame while alignment is held.
- Presents payload bytes on a valid/ready stream with sof/eof/type sidebands through a commit/rewind FIFO. Partial or aborted frames never become visible downstream.

Parameters:
- PAYLOAD_LEN, 10: payload bytes per frame, carried at positions 1..PAYLOAD_LEN.
- FIFO_AW, 5: FIFO address width; depth = 2**FIFO_AW. Must satisfy depth >= PAYLOAD_LEN.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- rx_data  in  8  byte stream, cycle-aligned with fr_byte_position
- fr_byte_position  in  4  byte position from aligner (header MSB at 0)
- frame_detect  in  1  alignment indication from aligner
- out_data  out  8  payload byte
- out_valid  out  1  out_data/sidebands valid
- out_ready  in  1  downstream accepts
- out_sof  out  1  first payload byte of frame
- out_eof  out  1  last payload byte of frame
- out_type  out  1  0 = header AA/AF, 1 = header 55/BA
- fifo_level  out  FIFO_AW+1  committed, unread entries
- frame_ok_cnt  out  8  frames committed, saturating
- frame_drop_cnt  out  8  frames dropped, saturating

Behaviour:
- Reset (synchronous, active-high): state HUNT, rd/wr/commit pointers 0, out_valid 0, fifo_level 0, both counters 0.
- Start condition: fr_byte_position==0 and rx_data is 0xAF or 0xBA. The type is 0 for 0xAF and 1 for 0xBA.
- free = 2**FIFO_AW - (commit_ptr - rd_ptr). Pointers are FIFO_AW+1 bits and wrap naturally.

State machine, HUNT:
- Start, frame_detect=1, free>=PAYLOAD_LEN: go to COLLECT, latch type, exp=1.
- Start, frame_detect=1, free<PAYLOAD_LEN: go to DROP, drop_cnt+1.
- Start with frame_detect=0: stay in HUNT, no count.

State machine, COLLECT (once per cycle):
- Normal cycle (frame_detect=1 and fr_byte_position==exp):
  - Write {rx_data, sof=(exp==1), eof=(exp==PAYLOAD_LEN), type} at wr_ptr; wr_ptr+1, exp+1.
  - On the write with exp==PAYLOAD_LEN: commit_ptr = wr_ptr+1, ok_cnt+1, go to HUNT.
- Abort (frame_detect=0 or position mismatch):
  - wr_ptr rewinds to commit_ptr, drop_cnt+1.
  - The same cycle is evaluated as a HUNT start condition, so a new frame beginning in the abort cycle is not lost.

State machine, DROP:
- Return to HUNT when fr_byte_position==PAYLOAD_LEN or frame_detect=0. No writes occur.

Output side:
- First-word fall-through. out_valid = (commit_ptr != rd_ptr); out_data and sidebands come from the entry at rd_ptr.
- A transfer occurs when out_valid && out_ready; rd_ptr+1.
- While out_valid && !out_ready, all outputs hold stable.
- Uncommitted entries are never visible.

Latency and levels:
- The first byte of a frame appears on out_valid one cycle after the eof byte is sampled. That is the commit edge; there is no earlier visibility.
- fifo_level = commit_ptr - rd_ptr, registered with the pointers.

Simultaneous events:
- Read and commit in the same cycle are both honoured.
- A read during COLLECT only increases free space.

Counters:
- Both saturate at 255; they never wrap.

Optional Feature:
- Macro: FPE_STATS_EN.
- Defined: frame_ok_cnt and frame_drop_cnt behave as specified above.
- Undefined: counter logic is not built; both ports are tied to 0. Extraction, drop and rewind behaviour is unchanged.

Test Plan:
1. Reset, frame_detect=1, out_ready=1; feed AA, then AF at pos 0, then 01..0A at pos 1..10 -> 10 bytes 01..0A, out_sof on 01, out_eof on 0A, out_type=0, ok_cnt=1. out_valid first rises one cycle after 0A is sampled.
2. Feed 55, BA, payload with frame_detect=0 -> out_valid stays 0, both counters 0, fifo_level 0.
3. 55/BA frame with frame_detect falling at pos 5 -> no bytes output, drop_cnt=1, fifo_level 0. The next good AA/AF frame is delivered intact with out_type=0.
4. FIFO_AW=5, out_ready=0, four back-to-back good frames -> 3 committed (fifo_level=30), 4th dropped (free=2), drop_cnt=1. Then out_ready=1 drains exactly 30 bytes in order with correct sof/eof.
5. Frame in progress; pos 3 is followed by pos 0 with BA and a full frame -> partial frame discarded, drop_cnt=1. The new frame is collected from that cycle with out_type=1.
6. out_ready toggled 1/0 every cycle during drain -> out_data/sidebands stable while stalled; no loss or duplication. Repeat with FPE_STATS_EN undefined -> counters read 0 and the data path is unchanged.

Source files
------------

// File: rtl/frame_payload_extractor.sv
// Extracts PAYLOAD_LEN payload bytes from aligned frames into a commit/rewind FIFO
// with a first-word fall-through output stream. Optional counters: define FPE_STATS_EN.
module frame_payload_extractor #(
    parameter int PAYLOAD_LEN = 10,
    parameter int FIFO_AW     = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         rx_data,
    input  logic [3:0]         fr_byte_position,
    input  logic               frame_detect,
    output logic [7:0]         out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_sof,
    output logic               out_eof,
    output logic               out_type,
    output logic [FIFO_AW:0]   fifo_level,
    output logic [7:0]         frame_ok_cnt,
    output logic [7:0]         frame_drop_cnt
);

    localparam int DEPTH = 2 ** FIFO_AW;
    localparam logic [FIFO_AW:0] DEPTH_V = (FIFO_AW + 1)'(DEPTH);
    localparam logic [FIFO_AW:0] LEN_V   = (FIFO_AW + 1)'(PAYLOAD_LEN);
    localparam logic [3:0]       LEN_P   = 4'(PAYLOAD_LEN);

    typedef enum logic [1:0] {HUNT, COLLECT, DROP} state_t;

    state_t             state, state_nx;
    logic [FIFO_AW:0]   wr_ptr, commit_ptr, rd_ptr;
    logic [FIFO_AW:0]   wr_nx, commit_nx;
    logic [FIFO_AW:0]   used, free;
    logic [3:0]         exp_pos, exp_nx;
    logic               type_q, type_nx;
    logic               we, ok_inc, hunt_eval, start, room;
    logic [1:0]         drop_add;
    logic [10:0]        mem [DEPTH];
    logic [10:0]        head;

    assign used  = commit_ptr - rd_ptr;
    assign free  = DEPTH_V - used;
    assign room  = free >= LEN_V;
    assign start = (fr_byte_position == 4'd0) && (rx_data == 8'hAF || rx_data == 8'hBA);

    always_comb begin
        state_nx  = state;
        wr_nx     = wr_ptr;
        commit_nx = commit_ptr;
        exp_nx    = exp_pos;
        type_nx   = type_q;
        we        = 1'b0;
        ok_inc    = 1'b0;
        drop_add  = 2'd0;
        hunt_eval = 1'b0;
        case (state)
            HUNT: hunt_eval = 1'b1;
            COLLECT: begin
                if (frame_detect && fr_byte_position == exp_pos) begin
                    we     = 1'b1;
                    wr_nx  = wr_ptr + 1'b1;
                    exp_nx = exp_pos + 4'd1;
                    if (exp_pos == LEN_P) begin
                        commit_nx = wr_ptr + 1'b1;
                        ok_inc    = 1'b1;
                        state_nx  = HUNT;
                    end
                end else begin
                    // Abort rewinds, then the same byte may open a new frame.
                    wr_nx     = commit_ptr;
                    drop_add  = 2'd1;
                    state_nx  = HUNT;
                    hunt_eval = 1'b1;
                end
            end
            DROP: begin
                if (fr_byte_position == LEN_P || !frame_detect)
                    state_nx = HUNT;
            end
            default: state_nx = HUNT;
        endcase
        if (hunt_eval && start && frame_detect) begin
            if (room) begin
                state_nx = COLLECT;
                type_nx  = (rx_data == 8'hBA);
                exp_nx   = 4'd1;
            end else begin
                state_nx = DROP;
                drop_add = drop_add + 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= HUNT;
            wr_ptr     <= '0;
            commit_ptr <= '0;
            rd_ptr     <= '0;
            exp_pos    <= 4'd1;
            type_q     <= 1'b0;
        end else begin
            state      <= state_nx;
            wr_ptr     <= wr_nx;
            commit_ptr <= commit_nx;
            exp_pos    <= exp_nx;
            type_q     <= type_nx;
            if (out_valid && out_ready)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (we)
            mem[wr_ptr[FIFO_AW-1:0]] <= {type_q, exp_pos == LEN_P, exp_pos == 4'd1, rx_data};
    end

    assign head       = mem[rd_ptr[FIFO_AW-1:0]];
    assign out_valid  = (commit_ptr != rd_ptr);
    assign out_data   = head[7:0];
    assign out_sof    = head[8];
    assign out_eof    = head[9];
    assign out_type   = head[10];
    assign fifo_level = used;

`ifdef FPE_STATS_EN
    logic [7:0] ok_cnt, drop_cnt;
    logic [8:0] drop_sum;

    assign drop_sum = {1'b0, drop_cnt} + 9'(drop_add);

    always_ff @(posedge clk) begin
        if (reset) begin
            ok_cnt   <= '0;
            drop_cnt <= '0;
        end else begin
            if (ok_inc && ok_cnt != 8'hFF)
                ok_cnt <= ok_cnt + 8'd1;
            drop_cnt <= (drop_sum > 9'd255) ? 8'hFF : drop_sum[7:0];
        end
    end

    assign frame_ok_cnt   = ok_cnt;
    assign frame_drop_cnt = drop_cnt;
`else
    logic stats_unused;
    assign stats_unused   = ^{ok_inc, drop_add};
    assign frame_ok_cnt   = '0;
    assign frame_drop_cnt = '0;
`endif

endmodule
